// File: rtl/ct_had_serial_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : ct_had_serial_shifter
//  Description : JTAG IR/DR serial shifter for the HAD debug TAP. The DR
//                length is set at run time. Reads append an odd-parity bit,
//                writes check a host-supplied parity bit, and the shift
//                count is checked against the selected length.
//  Revision    : 1.0 - initial release
// ============================================================================
module ct_had_serial_shifter #(
    parameter int DATA_W = 64,
    parameter int IR_W   = 8,
    parameter int LEN_W  = 7
) (
    input  logic              tclk,
    input  logic              trst_b,
    input  logic              io_serial_tdi,
    output logic              serial_io_tdo,
    input  logic              sm_serial_shift_ir,
    input  logic              sm_serial_capture_dr,
    input  logic              sm_serial_shift_dr,
    input  logic              sm_serial_update_dr,
    input  logic              sm_xx_write_en,
    input  logic [LEN_W-1:0]  ir_serial_dr_len,
    input  logic [DATA_W-1:0] regs_serial_data,
    output logic [DATA_W-1:0] serial_xx_data,
    output logic [IR_W-1:0]   serial_xx_ir,
    output logic              serial_xx_update_vld,
    output logic              serial_xx_len_err,
    output logic              serial_xx_parity_err
);

    // One extra bit so the counter can reach L+2 even when L == DATA_W.
    localparam int CNT_W = LEN_W + 1;

    logic [DATA_W-1:0] r_data;
    logic [IR_W-1:0]   r_ir;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic              r_par_in;
    logic              r_len_err;
    logic              r_par_err;
    logic              r_upd_vld;
    logic              r_tdo;

    logic [LEN_W-1:0]  w_len;
    logic [CNT_W-1:0]  w_len_x;
    logic [CNT_W-1:0]  w_len_p1;
    logic [CNT_W-1:0]  w_len_p2;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_shift;
    logic              w_cnt_lt;
    logic              w_cnt_eq;
    logic              w_len_bad;
    logic              w_par_ok;

    // Effective length: 0 or anything beyond DATA_W selects the full width.
    always_comb begin
        w_len = ir_serial_dr_len;
        if ((ir_serial_dr_len == '0) || (ir_serial_dr_len > LEN_W'(DATA_W))) begin
            w_len = LEN_W'(DATA_W);
        end
    end

    assign w_len_x  = {1'b0, w_len};
    assign w_len_p1 = w_len_x + CNT_W'(1);
    assign w_len_p2 = w_len_x + CNT_W'(2);

    // Bit mask of the active DR field [L-1:0].
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign w_mask[gi] = (CNT_W'(gi) < w_len_x);
    end

    // Right shift inside [L-1:0] with TDI entering at bit L-1; bits >= L stay 0.
    assign w_shift = ({1'b0, r_data[DATA_W-1:1]} & (w_mask >> 1))
                   | (DATA_W'(io_serial_tdi) << (w_len - LEN_W'(1)));

    assign w_cnt_lt  = (r_cnt < w_len_x);
    assign w_cnt_eq  = (r_cnt == w_len_x);
    assign w_len_bad = (r_cnt != w_len_p1);
    assign w_par_ok  = (r_par_in == r_par);

    // IR/DR shifting, shift counting, parity accumulation and update checks.
    always_ff @(posedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            r_ir      <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_par     <= 1'b1;
            r_par_in  <= 1'b0;
            r_len_err <= 1'b0;
            r_par_err <= 1'b0;
            r_upd_vld <= 1'b0;
        end else begin
            r_upd_vld <= 1'b0;
            if (sm_serial_shift_ir) begin
                r_ir <= {io_serial_tdi, r_ir[IR_W-1:1]};
            end else if (sm_serial_capture_dr) begin
                r_data    <= regs_serial_data & w_mask;
                r_cnt     <= '0;
                r_par     <= 1'b1;
                r_len_err <= 1'b0;
                r_par_err <= 1'b0;
            end else if (sm_serial_shift_dr) begin
                if (w_cnt_lt) begin
                    r_data <= w_shift;
                    r_par  <= r_par ^ (sm_xx_write_en ? io_serial_tdi : r_data[0]);
                    r_cnt  <= r_cnt + CNT_W'(1);
                end else if (w_cnt_eq) begin
                    if (sm_xx_write_en) begin
                        r_par_in <= io_serial_tdi;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_cnt < w_len_p2) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (sm_serial_update_dr) begin
                r_len_err <= w_len_bad;
                r_par_err <= sm_xx_write_en && !w_len_bad && !w_par_ok;
                r_upd_vld <= sm_xx_write_en && !w_len_bad && w_par_ok;
            end
        end
    end

    // TDO launches on the falling edge: data bits, then parity, then idle ones.
    always_ff @(negedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            r_tdo <= 1'b1;
        end else if (sm_serial_shift_dr && !sm_serial_shift_ir && !sm_serial_capture_dr
                     && !sm_xx_write_en) begin
            if (w_cnt_lt) begin
                r_tdo <= r_data[0];
            end else if (w_cnt_eq) begin
                r_tdo <= r_par;
            end else begin
                r_tdo <= 1'b1;
            end
        end
    end

    assign serial_io_tdo        = r_tdo;
    assign serial_xx_data       = r_data;
    assign serial_xx_ir         = r_ir;
    assign serial_xx_update_vld = r_upd_vld;
    assign serial_xx_len_err    = r_len_err;
    assign serial_xx_parity_err = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_ct_had_serial_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_had_serial_shifter
//  Description : Self-checking bench for ct_had_serial_shifter. Table-driven
//                DR accesses with a TDO scoreboard, plus hand-written
//                sequences for IR shifting, flag clearing and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_had_serial_shifter;

    logic        tclk;
    logic        trst_b;
    logic        io_serial_tdi;
    logic        serial_io_tdo;
    logic        sm_serial_shift_ir;
    logic        sm_serial_capture_dr;
    logic        sm_serial_shift_dr;
    logic        sm_serial_update_dr;
    logic        sm_xx_write_en;
    logic [6:0]  ir_serial_dr_len;
    logic [63:0] regs_serial_data;
    logic [63:0] serial_xx_data;
    logic [7:0]  serial_xx_ir;
    logic        serial_xx_update_vld;
    logic        serial_xx_len_err;
    logic        serial_xx_parity_err;

    ct_had_serial_shifter #(.DATA_W(64), .IR_W(8), .LEN_W(7)) dut (
        .tclk                 (tclk),
        .trst_b               (trst_b),
        .io_serial_tdi        (io_serial_tdi),
        .serial_io_tdo        (serial_io_tdo),
        .sm_serial_shift_ir   (sm_serial_shift_ir),
        .sm_serial_capture_dr (sm_serial_capture_dr),
        .sm_serial_shift_dr   (sm_serial_shift_dr),
        .sm_serial_update_dr  (sm_serial_update_dr),
        .sm_xx_write_en       (sm_xx_write_en),
        .ir_serial_dr_len     (ir_serial_dr_len),
        .regs_serial_data     (regs_serial_data),
        .serial_xx_data       (serial_xx_data),
        .serial_xx_ir         (serial_xx_ir),
        .serial_xx_update_vld (serial_xx_update_vld),
        .serial_xx_len_err    (serial_xx_len_err),
        .serial_xx_parity_err (serial_xx_parity_err)
    );

    initial begin
        tclk = 1'b0;
        forever #5 tclk = ~tclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [6:0]  len;
        logic [63:0] regs;
        logic [63:0] wdata;
        int          nsh;
        bit          flip;
        bit          e_len;
        bit          e_par;
        bit          e_vld;
        bit          chk_data;
        logic [63:0] e_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];
    logic sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tclk);
        #1;
    endtask

    function automatic int eff_len(input logic [6:0] l);
        return ((l == 7'd0) || (l > 7'd64)) ? 64 : int'(l);
    endfunction

    function automatic logic [63:0] mask_of(input int l);
        logic [63:0] one = 64'd1;
        return (l >= 64) ? '1 : ((one << l) - 64'd1);
    endfunction

    // One complete capture / shift / update access with scoreboarded TDO.
    task automatic run_access(input int idx, input vec_t v);
        int          l;
        logic [63:0] m, rd, wd;
        logic        p_rd, p_wr, e, a;
        l    = eff_len(v.len);
        m    = mask_of(l);
        rd   = v.regs & m;
        wd   = v.wdata & m;
        p_rd = ~^rd;
        p_wr = (~^wd) ^ v.flip;
        sm_xx_write_en       = v.wr;
        ir_serial_dr_len     = v.len;
        regs_serial_data     = v.regs;
        sm_serial_capture_dr = 1'b1;
        step();
        sm_serial_capture_dr = 1'b0;
        sm_serial_shift_dr   = 1'b1;
        for (int k = 0; k < v.nsh; k++) begin
            if (v.wr) begin
                io_serial_tdi = (k < l) ? wd[k] : ((k == l) ? p_wr : 1'b0);
            end else begin
                io_serial_tdi = 1'b0;
                e = (k < l) ? rd[k] : ((k == l) ? p_rd : 1'b1);
                sb.push_back(e);
            end
            @(negedge tclk);
            #1;
            if (!v.wr) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_tdo_sb_empty_k%0d", idx, k), 64'd1, 64'd0);
                end else begin
                    a = sb.pop_front();
                    chk($sformatf("v%0d_tdo_k%0d", idx, k), 64'(serial_io_tdo), 64'(a));
                end
            end
            @(posedge tclk);
            #1;
        end
        sm_serial_shift_dr  = 1'b0;
        io_serial_tdi       = 1'b0;
        sm_serial_update_dr = 1'b1;
        step();
        sm_serial_update_dr = 1'b0;
        chk($sformatf("v%0d_len_err", idx), 64'(serial_xx_len_err), 64'(v.e_len));
        chk($sformatf("v%0d_par_err", idx), 64'(serial_xx_parity_err), 64'(v.e_par));
        chk($sformatf("v%0d_upd_vld", idx), 64'(serial_xx_update_vld), 64'(v.e_vld));
        if (v.chk_data) begin
            chk($sformatf("v%0d_data", idx), serial_xx_data, v.e_data);
        end
        step();
        chk($sformatf("v%0d_upd_vld_off", idx), 64'(serial_xx_update_vld), 64'd0);
        chk($sformatf("v%0d_len_err_hold", idx), 64'(serial_xx_len_err), 64'(v.e_len));
    endtask

    initial begin
        logic [7:0] irv;
        //          wr len     regs                    wdata                   nsh flip len par vld chk data
        vt[0]  = '{1'b0, 7'd8,   64'hA5,                64'h0,                  9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        vt[1]  = '{1'b1, 7'd32,  64'h0,                 64'h12345678,           33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h12345678};
        vt[2]  = '{1'b1, 7'd32,  64'h0,                 64'h12345678,           33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h12345678};
        vt[3]  = '{1'b1, 7'd16,  64'h0,                 64'hBEEF,               10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vt[4]  = '{1'b1, 7'd16,  64'h0,                 64'hBEEF,               20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vt[5]  = '{1'b0, 7'd0,   64'hFFFFFFFFFFFFFFFF,  64'h0,                  65, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        vt[6]  = '{1'b1, 7'd0,   64'h0,                 64'hDEADBEEF01234567,   65, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF01234567};
        vt[7]  = '{1'b1, 7'd100, 64'h0,                 64'h8000000000000001,   65, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000000000000001};
        vt[8]  = '{1'b0, 7'd4,   64'hFFFFFFFFFFFFFFF3,  64'h0,                  5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        vt[9]  = '{1'b0, 7'd4,   64'h3,                 64'h0,                  7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vt[10] = '{1'b1, 7'd5,   64'h0,                 64'h1F,                 6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1F};
        vt[11] = '{1'b1, 7'd1,   64'h0,                 64'h1,                  2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1};
        vt[12] = '{1'b1, 7'd16,  64'h0,                 64'hBEEF,               16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vt[13] = '{1'b0, 7'd1,   64'h1,                 64'h0,                  2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};

        trst_b               = 1'b0;
        io_serial_tdi        = 1'b0;
        sm_serial_shift_ir   = 1'b0;
        sm_serial_capture_dr = 1'b0;
        sm_serial_shift_dr   = 1'b0;
        sm_serial_update_dr  = 1'b0;
        sm_xx_write_en       = 1'b0;
        ir_serial_dr_len     = 7'd8;
        regs_serial_data     = 64'h0;
        repeat (3) step();

        chk("rst_tdo",     64'(serial_io_tdo),        64'd1);
        chk("rst_data",    serial_xx_data,             64'd0);
        chk("rst_ir",      64'(serial_xx_ir),          64'd0);
        chk("rst_vld",     64'(serial_xx_update_vld),  64'd0);
        chk("rst_len_err", 64'(serial_xx_len_err),     64'd0);
        chk("rst_par_err", 64'(serial_xx_parity_err),  64'd0);
        trst_b = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            run_access(i, vt[i]);
        end

        // Last table entry was a read with L=1, regs=1: TDO left at parity 0.
        irv = 8'h1F;
        sm_serial_shift_ir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            io_serial_tdi = irv[k];
            step();
        end
        sm_serial_shift_ir = 1'b0;
        io_serial_tdi      = 1'b0;
        @(negedge tclk);
        #1;
        chk("ir_value",      64'(serial_xx_ir),  64'h1F);
        chk("ir_tdo_hold",   64'(serial_io_tdo), 64'd0);
        chk("ir_data_hold",  serial_xx_data,     64'd0);
        @(posedge tclk);
        #1;
        // Counter must still hold L+1 from the read, so a bare update is clean.
        sm_serial_update_dr = 1'b1;
        step();
        sm_serial_update_dr = 1'b0;
        chk("ir_cnt_hold_len_err", 64'(serial_xx_len_err),    64'd0);
        chk("ir_read_no_vld",      64'(serial_xx_update_vld), 64'd0);

        // Capture clears a pending parity error.
        run_access(100, vt[2]);
        sm_serial_capture_dr = 1'b1;
        step();
        sm_serial_capture_dr = 1'b0;
        chk("cap_clr_par_err", 64'(serial_xx_parity_err), 64'd0);

        // Capture clears a pending length error.
        run_access(101, vt[3]);
        sm_serial_capture_dr = 1'b1;
        step();
        sm_serial_capture_dr = 1'b0;
        chk("cap_clr_len_err", 64'(serial_xx_len_err), 64'd0);

        // Reset in the middle of a read scan of all zeros.
        sm_xx_write_en       = 1'b0;
        ir_serial_dr_len     = 7'd0;
        regs_serial_data     = 64'h0;
        sm_serial_capture_dr = 1'b1;
        step();
        sm_serial_capture_dr = 1'b0;
        sm_serial_shift_dr   = 1'b1;
        io_serial_tdi        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge tclk);
            #1;
            chk($sformatf("abort_tdo_k%0d", k), 64'(serial_io_tdo), 64'd0);
            @(posedge tclk);
            #1;
        end
        chk("abort_data_pre", serial_xx_data, 64'hFFC0000000000000);
        trst_b = 1'b0;
        #1;
        chk("abort_tdo",     64'(serial_io_tdo),        64'd1);
        chk("abort_data",    serial_xx_data,             64'd0);
        chk("abort_ir",      64'(serial_xx_ir),          64'd0);
        chk("abort_vld",     64'(serial_xx_update_vld),  64'd0);
        chk("abort_len_err", 64'(serial_xx_len_err),     64'd0);
        chk("abort_par_err", 64'(serial_xx_parity_err),  64'd0);
        sm_serial_shift_dr = 1'b0;
        io_serial_tdi      = 1'b0;
        #1;
        trst_b = 1'b1;
        step();
        sm_xx_write_en      = 1'b1;
        sm_serial_update_dr = 1'b1;
        step();
        sm_serial_update_dr = 1'b0;
        chk("abort_upd_len_err", 64'(serial_xx_len_err),    64'd1);
        chk("abort_upd_no_vld",  64'(serial_xx_update_vld), 64'd0);
        chk("abort_upd_par_err", 64'(serial_xx_parity_err), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
